// File: rtl/ysyx_22040386_csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, control-state encodings,
// mstatus field positions and the ECALL cause code.
package ysyx_22040386_csr_pkg;

  localparam logic [11:0] CSR_MCYCLE   = 12'hb00;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  typedef enum logic [2:0] {
    CSR_IDLE  = 3'd0,
    CSR_RS    = 3'd1,
    CSR_RW    = 3'd2,
    CSR_ECALL = 3'd3,
    CSR_MRET  = 3'd4
  } csr_state_e;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

endpackage

// File: rtl/ysyx_22040386_csr_trap.sv
// Trap sequencer: combinational next-state of mstatus/mepc/mcause and the
// PC redirect for ECALL and MRET. State must already be gated by valid.
module ysyx_22040386_csr_trap
  import ysyx_22040386_csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE = CAUSE_ECALL_M
) (
  input  csr_state_e        state,
  input  logic [XLEN-1:0]   mstatus,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  input  logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   next_mstatus,
  output logic [XLEN-1:0]   next_mepc,
  output logic [XLEN-1:0]   next_mcause,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc
);

  always_comb begin
    next_mstatus = mstatus;
    next_mepc    = mepc;
    next_mcause  = '0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    case (state)
      CSR_ECALL: begin
        next_mstatus[MS_MPIE]             = mstatus[MS_MIE];
        next_mstatus[MS_MIE]              = 1'b0;
        next_mstatus[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        next_mepc                         = pc;
        next_mcause                       = ECALL_CAUSE;
        redirect                          = 1'b1;
        // direct mode only: vector mode bits are ignored
        redirect_pc                       = {mtvec[XLEN-1:2], 2'b00};
      end
      CSR_MRET: begin
        next_mstatus[MS_MIE]              = mstatus[MS_MPIE];
        next_mstatus[MS_MPIE]             = 1'b1;
        next_mstatus[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        redirect                          = 1'b1;
        redirect_pc                       = mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22040386_csr_file.sv
// Machine-mode CSR register file: register bank, address decode, mcycle and
// the writeback of trap updates produced by ysyx_22040386_csr_trap.
module ysyx_22040386_csr_file
  import ysyx_22040386_csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000a_0000_1800,
  parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11
) (
  input  logic              i_CSR_clk,
  input  logic              i_CSR_rst_n,
  input  logic              i_CSR_valid,
  input  logic              i_CSR_ren,
  input  logic              i_CSR_wen,
  input  logic [2:0]        i_CSR_state,
  input  logic [11:0]       i_CSR_raddr,
  input  logic [11:0]       i_CSR_waddr,
  input  logic [XLEN-1:0]   i_CSR_wr_data,
  input  logic [XLEN-1:0]   i_CSR_pc,
  output logic [XLEN-1:0]   o_CSR_rd_data,
  output logic              o_CSR_redirect,
  output logic [XLEN-1:0]   o_CSR_redirect_pc,
  output logic              o_CSR_bad_addr
);

  logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, mie, mip, mscratch, mcycle;

  csr_state_e state, trap_state;
  assign state      = csr_state_e'(i_CSR_state);
  assign trap_state = i_CSR_valid ? state : CSR_IDLE;

  // read port
  logic [XLEN-1:0] rd_val;
  logic            rd_hit;
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    case (i_CSR_raddr)
      CSR_MCYCLE:   rd_val = mcycle;
      CSR_MSTATUS:  rd_val = mstatus;
      CSR_MIE:      rd_val = mie;
      CSR_MTVEC:    rd_val = mtvec;
      CSR_MSCRATCH: rd_val = mscratch;
      CSR_MEPC:     rd_val = mepc;
      CSR_MCAUSE:   rd_val = mcause;
      CSR_MIP:      rd_val = mip;
      default:      rd_hit = 1'b0;
    endcase
  end

  assign o_CSR_rd_data  = i_CSR_ren ? rd_val : '0;
  assign o_CSR_bad_addr = i_CSR_ren & i_CSR_valid & ~rd_hit;

  // old value at waddr feeds the set-bits merge
  logic [XLEN-1:0] wr_old;
  always_comb begin
    wr_old = '0;
    case (i_CSR_waddr)
      CSR_MCYCLE:   wr_old = mcycle;
      CSR_MSTATUS:  wr_old = mstatus;
      CSR_MIE:      wr_old = mie;
      CSR_MTVEC:    wr_old = mtvec;
      CSR_MSCRATCH: wr_old = mscratch;
      CSR_MEPC:     wr_old = mepc;
      CSR_MCAUSE:   wr_old = mcause;
      CSR_MIP:      wr_old = mip;
      default:      wr_old = '0;
    endcase
  end

  logic            wr_act;
  logic [XLEN-1:0] wr_val;
  assign wr_act = i_CSR_valid & i_CSR_wen & ((state == CSR_RS) | (state == CSR_RW));
  assign wr_val = (state == CSR_RS) ? (wr_old | i_CSR_wr_data) : i_CSR_wr_data;

  logic [XLEN-1:0] nx_mstatus, nx_mepc, nx_mcause;
  logic            is_ecall;
  assign is_ecall = i_CSR_valid & (state == CSR_ECALL);

  ysyx_22040386_csr_trap #(
    .XLEN        (XLEN),
    .ECALL_CAUSE (ECALL_CAUSE)
  ) u_trap (
    .state        (trap_state),
    .mstatus      (mstatus),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .pc           (i_CSR_pc),
    .next_mstatus (nx_mstatus),
    .next_mepc    (nx_mepc),
    .next_mcause  (nx_mcause),
    .redirect     (o_CSR_redirect),
    .redirect_pc  (o_CSR_redirect_pc)
  );

  always_ff @(posedge i_CSR_clk or negedge i_CSR_rst_n) begin
    if (!i_CSR_rst_n) begin
      mstatus  <= MSTATUS_RST;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mie      <= '0;
      mip      <= '0;
      mscratch <= '0;
      mcycle   <= '0;
    end else begin
      // a software write replaces this cycle's increment
      if (wr_act && i_CSR_waddr == CSR_MCYCLE) mcycle <= wr_val;
      else                                     mcycle <= mcycle + XLEN'(1);

      if (o_CSR_redirect)                            mstatus <= nx_mstatus;
      else if (wr_act && i_CSR_waddr == CSR_MSTATUS) mstatus <= wr_val;

      if (is_ecall) begin
        mepc   <= nx_mepc;
        mcause <= nx_mcause;
      end else begin
        if (wr_act && i_CSR_waddr == CSR_MEPC)   mepc   <= wr_val;
        if (wr_act && i_CSR_waddr == CSR_MCAUSE) mcause <= wr_val;
      end

      if (wr_act && i_CSR_waddr == CSR_MTVEC)    mtvec    <= wr_val;
      if (wr_act && i_CSR_waddr == CSR_MIE)      mie      <= wr_val;
      if (wr_act && i_CSR_waddr == CSR_MIP)      mip      <= wr_val;
      if (wr_act && i_CSR_waddr == CSR_MSCRATCH) mscratch <= wr_val;
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_csr_file.sv
// Scoreboard bench for the CSR file: expectations queued with each stimulus
// cycle and compared against the combinational outputs at the falling edge.
module tb_ysyx_22040386_csr_file;
  import ysyx_22040386_csr_pkg::*;

  logic        clk, rst_n, valid, ren, wen;
  logic [2:0]  state;
  logic [11:0] raddr, waddr;
  logic [63:0] wr_data, pc;
  logic [63:0] rd_data, redirect_pc;
  logic        redirect, bad_addr;

  ysyx_22040386_csr_file dut (
    .i_CSR_clk         (clk),
    .i_CSR_rst_n       (rst_n),
    .i_CSR_valid       (valid),
    .i_CSR_ren         (ren),
    .i_CSR_wen         (wen),
    .i_CSR_state       (state),
    .i_CSR_raddr       (raddr),
    .i_CSR_waddr       (waddr),
    .i_CSR_wr_data     (wr_data),
    .i_CSR_pc          (pc),
    .o_CSR_rd_data     (rd_data),
    .o_CSR_redirect    (redirect),
    .o_CSR_redirect_pc (redirect_pc),
    .o_CSR_bad_addr    (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_RD = 0, K_REDIR = 1, K_RPC = 2, K_BAD = 3;
  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rst_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e_mon = sb.pop_front();
      case (e_mon.kind)
        K_RD:    chk(e_mon.tag, rd_data, e_mon.val);
        K_REDIR: chk(e_mon.tag, {63'd0, redirect}, e_mon.val);
        K_RPC:   chk(e_mon.tag, redirect_pc, e_mon.val);
        default: chk(e_mon.tag, {63'd0, bad_addr}, e_mon.val);
      endcase
    end
  end

  task automatic step(input logic v, input logic r, input logic w, input logic [2:0] st,
                      input logic [11:0] ra, input logic [11:0] wa,
                      input logic [63:0] wd, input logic [63:0] p);
    @(posedge clk);
    #1;
    rst_n = rst_q; valid = v; ren = r; wen = w; state = st;
    raddr = ra; waddr = wa; wr_data = wd; pc = p;
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, 1'b1, 1'b0, 3'd0, a, 12'h0, 64'h0, 64'h0);
  endtask
  task automatic rw(input logic [11:0] a, input logic [63:0] d);
    step(1'b1, 1'b1, 1'b1, 3'd2, a, a, d, 64'h0);
  endtask
  task automatic rs(input logic [11:0] a, input logic [63:0] d);
    step(1'b1, 1'b1, 1'b1, 3'd1, a, a, d, 64'h0);
  endtask
  // a stray write to mepc rides along to show the trap update wins
  task automatic ecall(input logic [63:0] p, input logic [11:0] ra);
    step(1'b1, 1'b1, 1'b1, 3'd3, ra, CSR_MEPC, 64'h999, p);
  endtask
  task automatic mret(input logic v, input logic [11:0] ra);
    step(v, 1'b1, 1'b0, 3'd4, ra, 12'h0, 64'h0, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_q = 1'b0; valid = 1'b0; ren = 1'b0; wen = 1'b0; state = 3'd0;
    raddr = '0; waddr = '0; wr_data = '0; pc = '0;

    step(1'b1, 1'b0, 1'b0, 3'd0, CSR_MSTATUS, 12'h0, 64'h0, 64'h0);
    push("rst_rd_off", K_RD, 64'h0);
    push("rst_redir", K_REDIR, 64'h0);
    rd(CSR_MSTATUS);  push("rst_mstatus", K_RD, 64'ha_0000_1800);

    // mid-run reset
    rst_q = 1'b1;
    rw(CSR_MSCRATCH, 64'h1234); push("mscratch_old", K_RD, 64'h0);
    rw(CSR_MCYCLE, 64'h55);
    rd(CSR_MCYCLE);   push("mcycle_55", K_RD, 64'h55);
    rst_q = 1'b0;
    rd(CSR_MCYCLE);   push("rst_mcycle", K_RD, 64'h0);
    rd(CSR_MSCRATCH); push("rst_mscratch", K_RD, 64'h0);
    rd(CSR_MSTATUS);  push("rst_mstatus2", K_RD, 64'ha_0000_1800);
    rst_q = 1'b1;
    rd(CSR_MCYCLE);   push("rel_mcycle0", K_RD, 64'h0);
    rd(CSR_MCYCLE);   push("rel_mcycle1", K_RD, 64'h1);
    rd(CSR_MCYCLE);   push("rel_mcycle2", K_RD, 64'h2);

    rw(CSR_MTVEC, 64'h8000_0100); push("mtvec_old", K_RD, 64'h0);
    rd(CSR_MTVEC);    push("mtvec_new", K_RD, 64'h8000_0100);
    rs(CSR_MSTATUS, 64'h8); push("rs_old", K_RD, 64'ha_0000_1800);
    rs(CSR_MSTATUS, 64'h0); push("rs_set", K_RD, 64'ha_0000_1808);
    rd(CSR_MSTATUS);  push("rs_zero", K_RD, 64'ha_0000_1808);

    rw(CSR_MTVEC, 64'h8000_0103); push("mtvec_old2", K_RD, 64'h8000_0100);
    ecall(64'h8000_0040, CSR_MSTATUS);
    push("ecall_rd", K_RD, 64'ha_0000_1808);
    push("ecall_redir", K_REDIR, 64'h1);
    push("ecall_rpc", K_RPC, 64'h8000_0100);
    mret(1'b1, CSR_MSTATUS);
    push("ecall_mstatus", K_RD, 64'ha_0000_1880);
    push("mret_redir", K_REDIR, 64'h1);
    push("mret_rpc", K_RPC, 64'h8000_0040);
    rd(CSR_MSTATUS);  push("mret_mstatus", K_RD, 64'ha_0000_1888);
    rd(CSR_MEPC);     push("ecall_mepc", K_RD, 64'h8000_0040);
    rd(CSR_MCAUSE);   push("ecall_mcause", K_RD, 64'd11);

    rw(CSR_MSTATUS, 64'h1808); push("ms_old", K_RD, 64'ha_0000_1888);
    mret(1'b0, CSR_MSTATUS);
    push("nv_redir", K_REDIR, 64'h0);
    push("nv_rd", K_RD, 64'h1808);
    rd(CSR_MSTATUS);  push("nv_nochg", K_RD, 64'h1808);
    push("bad_valid_hit", K_BAD, 64'h0);

    rw(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(CSR_MCYCLE);   push("mcycle_max", K_RD, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(CSR_MCYCLE);   push("mcycle_wrap", K_RD, 64'h0);
    rw(CSR_MCYCLE, 64'h10);
    rd(CSR_MCYCLE);   push("mcycle_w10", K_RD, 64'h10);
    rd(CSR_MCYCLE);   push("mcycle_inc", K_RD, 64'h11);

    rd(12'h7C0);      push("bad_rd", K_RD, 64'h0);
    push("bad_flag", K_BAD, 64'h1);
    rw(12'h7C0, 64'hdead); push("bad_wr_rd", K_RD, 64'h0);
    rd(CSR_MTVEC);    push("bad_wr_mtvec", K_RD, 64'h8000_0103);
    rd(CSR_MSCRATCH); push("bad_wr_mscr", K_RD, 64'h0);
    rd(CSR_MIE);      push("bad_wr_mie", K_RD, 64'h0);
    rd(CSR_MIP);      push("bad_wr_mip", K_RD, 64'h0);
    rw(CSR_MIE, 64'h888);
    rw(CSR_MIP, 64'h80); push("mip_old", K_RD, 64'h0);
    rd(CSR_MIE);      push("mie_rw", K_RD, 64'h888);
    rd(CSR_MIP);      push("mip_rw", K_RD, 64'h80);

    @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040386_csr_file.md
Name: ysyx_22040386_csr_file

Overview:
Machine-mode CSR register file and trap sequencer. It is the responder for the CSR control bundle the decode stage emits (ren/wen/state/raddr/waddr/wr_data/ecall/mret).
- Holds mstatus, mtvec, mepc, mcause, mie, mip, mscratch and mcycle.
- Returns the old CSR value for rd writeback.
- Drives a PC redirect on ecall/mret.
- Sits beside EXU; its read data is muxed into the rd writeback path.

Parameters:
XLEN, 64, CSR data width
MSTATUS_RST, 64'h0000_000a_0000_1800, mstatus reset value (MPP=2'b11)
ECALL_CAUSE, 64'd11, mcause value written on ecall from M-mode

Ports:
i_CSR_clk  in  1  clock
i_CSR_rst_n  in  1  asynchronous active-low reset
i_CSR_valid  in  1  instruction in this stage is live; gates all architectural updates except mcycle
i_CSR_ren  in  1  read enable
i_CSR_wen  in  1  write enable
i_CSR_state  in  3  0 IDLE, 1 CSRRS, 2 CSRRW, 3 ECALL, 4 MRET
i_CSR_raddr  in  12  read address
i_CSR_waddr  in  12  write address
i_CSR_wr_data  in  64  rs1 value or zero-extended uimm
i_CSR_pc  in  64  PC of the instruction in this stage
o_CSR_rd_data  out  64  old CSR value (combinational)
o_CSR_redirect  out  1  take o_CSR_redirect_pc at next edge
o_CSR_redirect_pc  out  64  trap/return target
o_CSR_bad_addr  out  1  ren&valid with unimplemented raddr (debug only)

Behaviour:
- Reset (async, rst_n low): mstatus=MSTATUS_RST; all other CSRs 0; outputs are combinational from this state (rd_data 0 when ren=0, redirect 0).
- Read, combinational:
  - rd_data = CSR[raddr] when ren, else 0.
  - Unimplemented address reads 0 and asserts bad_addr when valid.
- Writes take effect at the next rising edge. An instruction in the following cycle sees the new value; there is no bypass within a cycle.
- Write rules, only when valid & wen:
  - CSRRS: CSR[waddr] <= old | wr_data.
  - CSRRW: CSR[waddr] <= wr_data.
  - old is CSR[waddr] sampled in the same cycle.
  - Writes to unimplemented addresses are dropped silently.
- ECALL (valid & state==3), at the edge:
  - mepc <= pc; mcause <= ECALL_CAUSE.
  - mstatus.MPIE(bit7) <= MIE(bit3); MIE <= 0; MPP(12:11) <= 2'b11.
  - Same cycle: redirect=1, redirect_pc = {mtvec[63:2],2'b00}.
  - The generic write path is not applied; ECALL updates take precedence over wen.
- MRET (valid & state==4), at the edge:
  - mstatus.MIE <= MPIE; MPIE <= 1; MPP <= 2'b11 (M-only core).
  - Same cycle: redirect=1, redirect_pc = mepc (current value).
- IDLE, or valid=0: no CSR change, redirect=0.
- mcycle:
  - Increments by 1 every cycle regardless of valid and wraps 2^64-1 -> 0.
  - A software write to mcycle in the same cycle wins; the written value lands with no +1 that cycle.
- mip and mie are plain read/write storage; no interrupt sources.
- Back-to-back: ecall followed by mret on consecutive cycles returns to the pc saved by the ecall.

Decomposition:
- Shared package ysyx_22040386_csr_pkg:
  - CSR address constants (mcycle b00, mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344).
  - CSR_STATE encodings IDLE..MRET.
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11.
  - ECALL cause code.
- One sub-module, ysyx_22040386_csr_trap: pure function of (state, mstatus, mtvec, mepc, pc). It produces next_mstatus, next_mepc, next_mcause, redirect and redirect_pc. The top module owns the register bank, address decode and mcycle.

Test Plan:
- Reset: rst_n low mid-run with mcycle=0x55 -> all CSRs 0 immediately, mstatus=0xa00001800; after release, mcycle reads 1 after one edge and 2 after two.
- CSRRW mtvec: wr_data=0x8000_0100, ren/wen set -> rd_data=0 that cycle; next cycle read mtvec=0x8000_0100.
- CSRRS mstatus: wr_data=0x8 -> rd_data=0xa00001800, then mstatus=0xa00001808; repeat with wr_data=0 -> unchanged.
- ECALL: mtvec=0x8000_0103, mstatus MIE=1, pc=0x8000_0040 -> redirect=1, pc=0x8000_0100; next cycle mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1.
- MRET right after ECALL -> redirect_pc=0x8000_0040; mstatus MIE=1, MPIE=1, MPP=3. With valid=0 and state=MRET -> redirect=0, no change.
- Edge cases:
  - mcycle=0xFFFF_FFFF_FFFF_FFFF -> wraps to 0.
  - Write mcycle=0x10 -> reads 0x10 next cycle, then 0x11.
  - Read addr 0x7C0 -> rd_data=0, bad_addr=1.
  - Write to 0x7C0 -> no CSR changes.
